// File: rtl/scan_decoder_n.sv
// Registered active-low one-hot line decoder with direct and auto-scan modes.
// Every change of the driven line passes through DEAD all-high blanking cycles.
module scan_decoder_n #(
    parameter int WIDTH = 3,
    parameter int OUTS  = 8,
    parameter int DIV_W = 16,
    parameter int DEAD  = 2
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [1:0]       iEna,
    input  logic             iMode,
    input  logic [DIV_W-1:0] iDiv,
    input  logic [WIDTH-1:0] iData,
    output logic [OUTS-1:0]  oData,
    output logic [WIDTH-1:0] oSel,
    output logic             oTick
);

    localparam int BW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(OUTS - 1);
    localparam logic [BW-1:0] BLK_END = (DEAD > 0) ? BW'(DEAD - 1) : '0;

    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_idx, w_idx;
    logic [WIDTH-1:0] r_tgt, w_tgt;
    logic [DIV_W-1:0] r_div, w_div;
    logic [BW-1:0]    r_blk, w_blk;
    logic             r_mode;
    logic [OUTS-1:0]  r_data, w_data;
    logic [WIDTH-1:0] r_sel, w_sel;
    logic             r_tick, w_tick;
    logic             w_en, w_chg;
    logic [WIDTH-1:0] w_next;

    assign w_en   = (iEna == 2'b10);
    assign w_chg  = (iMode != r_mode);
    assign w_next = (r_idx == LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_tgt   = r_tgt;
        w_div   = r_div;
        w_blk   = r_blk;
        w_tick  = 1'b0;
        if (!w_en) begin
            w_state = IDLE;
            w_idx   = '0;
            w_tgt   = '0;
            w_div   = '0;
            w_blk   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state = DRIVE;
                    w_idx   = iMode ? '0 : iData;
                    w_tgt   = w_idx;
                    w_div   = '0;
                    w_blk   = '0;
                end
                DRIVE: begin
                    // Mode change outranks a scan terminal, so no tick here.
                    if (w_chg) begin
                        w_div = '0;
                        w_tgt = iMode ? '0 : iData;
                        if (DEAD > 0) begin
                            w_state = BLANK;
                            w_blk   = '0;
                        end else begin
                            w_idx = w_tgt;
                        end
                    end else if (!iMode) begin
                        if (iData != r_idx) begin
                            w_tgt = iData;
                            if (DEAD > 0) begin
                                w_state = BLANK;
                                w_blk   = '0;
                            end else begin
                                w_idx = iData;
                            end
                        end
                    end else if (r_div >= iDiv) begin
                        w_tick = 1'b1;
                        w_div  = '0;
                        w_tgt  = w_next;
                        if (DEAD > 0) begin
                            w_state = BLANK;
                            w_blk   = '0;
                        end else begin
                            w_idx = w_next;
                        end
                    end else begin
                        w_div = r_div + 1'b1;
                    end
                end
                BLANK: begin
                    if (w_chg) begin
                        w_div = '0;
                        w_tgt = iMode ? '0 : iData;
                    end else if (!iMode) begin
                        w_tgt = iData;
                    end
                    if (r_blk == BLK_END) begin
                        w_state = DRIVE;
                        w_idx   = w_tgt;
                        w_blk   = '0;
                    end else begin
                        w_blk = r_blk + 1'b1;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    // Out-of-range indices match no line, leaving the drive all high.
    always_comb begin
        w_data = '1;
        w_sel  = (w_state == BLANK) ? w_tgt : w_idx;
        if (w_state == DRIVE) begin
            for (int i = 0; i < OUTS; i++) begin
                if (w_idx == WIDTH'(i)) w_data[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_tgt   <= '0;
            r_div   <= '0;
            r_blk   <= '0;
            r_mode  <= 1'b0;
            r_data  <= '1;
            r_sel   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_tgt   <= w_tgt;
            r_div   <= w_div;
            r_blk   <= w_blk;
            r_mode  <= iMode;
            r_data  <= w_data;
            r_sel   <= w_sel;
            r_tick  <= w_tick;
        end
    end

    assign oData = r_data;
    assign oSel  = r_sel;
    assign oTick = r_tick;

endmodule

// File: tb/tb_scan_decoder_n.sv
// Directed bench for scan_decoder_n: four instances cover direct, blanking,
// scan wrap, disable, async reset, out-of-range and single-cycle scan.
module tb_scan_decoder_n;

    logic       clk;
    logic       rst_n;
    logic [1:0] ena  [4];
    logic       mode [4];
    logic [15:0] div [4];
    logic [2:0] dat  [4];
    logic [7:0] od0, od1;
    logic [4:0] od2, od3;
    logic [2:0] os   [4];
    logic       ot   [4];

    int n_chk = 0;
    int n_err = 0;

    scan_decoder_n #(.WIDTH(3), .OUTS(8), .DIV_W(16), .DEAD(0)) u0 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena[0]), .iMode(mode[0]),
        .iDiv(div[0]), .iData(dat[0]), .oData(od0), .oSel(os[0]),
        .oTick(ot[0]));
    scan_decoder_n #(.WIDTH(3), .OUTS(8), .DIV_W(16), .DEAD(2)) u1 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena[1]), .iMode(mode[1]),
        .iDiv(div[1]), .iData(dat[1]), .oData(od1), .oSel(os[1]),
        .oTick(ot[1]));
    scan_decoder_n #(.WIDTH(3), .OUTS(5), .DIV_W(16), .DEAD(1)) u2 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena[2]), .iMode(mode[2]),
        .iDiv(div[2]), .iData(dat[2]), .oData(od2), .oSel(os[2]),
        .oTick(ot[2]));
    scan_decoder_n #(.WIDTH(3), .OUTS(5), .DIV_W(16), .DEAD(0)) u3 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena[3]), .iMode(mode[3]),
        .iDiv(div[3]), .iData(dat[3]), .oData(od3), .oSel(os[3]),
        .oTick(ot[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e8;
        logic [4:0] e5;
        int n;
        for (int i = 0; i < 4; i++) begin
            ena[i]  = 2'b00;
            mode[i] = 1'b0;
            div[i]  = 16'd0;
            dat[i]  = 3'd0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", 32'(od0), 32'hFF);
        chk("rst_sel", 32'(os[0]), 32'd0);
        chk("rst_tick", 32'(ot[0]), 32'd0);
        step();
        step();
        #2 rst_n = 1'b1;

        // Direct decode sweep, no blanking
        ena[0] = 2'b10;
        for (int d = 0; d < 8; d++) begin
            dat[0] = 3'(d);
            step();
            e8 = ~(8'd1 << d);
            chk("dir_data", 32'(od0), 32'(e8));
            chk("dir_sel", 32'(os[0]), 32'(d));
        end
        ena[0] = 2'b01;
        step();
        chk("ena01", 32'(od0), 32'hFF);
        ena[0] = 2'b00;
        step();
        chk("ena00", 32'(od0), 32'hFF);
        ena[0] = 2'b11;
        step();
        chk("ena11", 32'(od0), 32'hFF);
        ena[0] = 2'b00;

        // Direct change with two blanking cycles
        ena[1] = 2'b10;
        dat[1] = 3'd1;
        step();
        chk("blk_d1", 32'(od1), 32'hFD);
        dat[1] = 3'd6;
        step();
        chk("blk_a_data", 32'(od1), 32'hFF);
        chk("blk_a_sel", 32'(os[1]), 32'd6);
        step();
        chk("blk_b_data", 32'(od1), 32'hFF);
        chk("blk_b_sel", 32'(os[1]), 32'd6);
        step();
        chk("blk_d6", 32'(od1), 32'hBF);
        chk("blk_d6_sel", 32'(os[1]), 32'd6);

        // Scan wrap: OUTS=5, iDiv=3, DEAD=1
        mode[2] = 1'b1;
        div[2]  = 16'd3;
        ena[2]  = 2'b10;
        step();
        for (int k = 0; k < 6; k++) begin
            e5 = ~(5'd1 << (k % 5));
            for (int c = 0; c < 4; c++) begin
                chk("scan_line", 32'(od2), 32'(e5));
                chk("scan_notick", 32'(ot[2]), 32'd0);
                step();
            end
            chk("scan_blank", 32'(od2), 32'h1F);
            chk("scan_tick", 32'(ot[2]), 32'd1);
            chk("scan_tgt", 32'(os[2]), 32'((k + 1) % 5));
            step();
        end

        // Disable while driving line 3
        n = 0;
        while (n < 40 && od2 !== 5'h17) begin
            step();
            n++;
        end
        chk("wait_line3", 32'(n < 40), 32'd1);
        ena[2] = 2'b00;
        step();
        chk("dis_data", 32'(od2), 32'h1F);
        chk("dis_tick", 32'(ot[2]), 32'd0);
        chk("dis_sel", 32'(os[2]), 32'd0);
        ena[2] = 2'b10;
        step();
        chk("reen_line0", 32'(od2), 32'h1E);
        chk("reen_sel", 32'(os[2]), 32'd0);

        // Asynchronous reset in the middle of BLANK
        n = 0;
        while (n < 40 && !(od2 === 5'h1F && ot[2] === 1'b1)) begin
            step();
            n++;
        end
        chk("wait_blank", 32'(n < 40), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(od2), 32'h1F);
        chk("arst_sel", 32'(os[2]), 32'd0);
        chk("arst_tick", 32'(ot[2]), 32'd0);
        #1 rst_n = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("rst_scan_l0", 32'(od2), 32'h1E);
            chk("rst_scan_nt", 32'(ot[2]), 32'd0);
            step();
        end
        chk("rst_scan_blk", 32'(od2), 32'h1F);
        chk("rst_scan_tk", 32'(ot[2]), 32'd1);
        ena[2] = 2'b00;

        // Out-of-range direct index, then iDiv=0 scan without blanking
        ena[3] = 2'b10;
        dat[3] = 3'd6;
        step();
        chk("oor_data", 32'(od3), 32'h1F);
        chk("oor_sel", 32'(os[3]), 32'd6);
        mode[3] = 1'b1;
        div[3]  = 16'd0;
        step();
        chk("mchg_line0", 32'(od3), 32'h1E);
        chk("mchg_notick", 32'(ot[3]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            e5 = ~(5'd1 << (k % 5));
            chk("fast_line", 32'(od3), 32'(e5));
            chk("fast_tick", 32'(ot[3]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
